music_player: RTL and testbench
===============================

MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BEAT_HZ, default 8, quarter-beat tick rate in Hz.
REQ-003 Parameter LAST_BEAT, default 127, final beat index of the song.
REQ-004 Parameter LOOP, default 1, 1 = wrap to beat 0 after LAST_BEAT, 0 = stop.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle pulse, begin playback from beat 0.
REQ-008 pause  input  1  single-cycle pulse, toggle pause/resume.
REQ-009 stop  input  1  single-cycle pulse, abort to idle.
REQ-010 tone  input  32  note frequency in Hz from the song table, a combinational function of beat_num.
REQ-011 beat_num  output  8  current quarter-beat index, drives song table.
REQ-012 audio  output  1  square-wave speaker drive.
REQ-013 busy  output  1  high in PLAY or PAUSE.
REQ-014 done  output  1  one-cycle pulse on song completion (LOOP=0 only).

Function
REQ-015 FSM states IDLE, PLAY, PAUSE, DONE; command priority stop > start > pause when asserted together.
REQ-016 stop in any state -> IDLE, beat_num=0, prescaler=0, audio=0.
REQ-017 start in IDLE or DONE -> PLAY, beat_num=0, prescaler=0; start in PLAY/PAUSE ignored.
REQ-018 pause in PLAY -> PAUSE; pause in PAUSE -> PLAY; pause in IDLE/DONE ignored.
REQ-019 Prescaler counts 0..CLK_HZ/BEAT_HZ-1 only in PLAY; terminal count = beat tick; frozen (value held) in PAUSE.
REQ-020 On beat tick with beat_num<LAST_BEAT: beat_num+1.
REQ-021 On beat tick with beat_num==LAST_BEAT: LOOP=1 -> beat_num=0, stay PLAY; LOOP=0 -> DONE, beat_num held at LAST_BEAT, done=1 for exactly that cycle.
REQ-022 Rest: tone==0 or tone>=20000 -> audio=0, no divide launched.
REQ-023 tone registered each cycle; when registered tone differs from last launched tone and is not a rest, divider computes half_period = CLK_HZ/(2*tone), integer floor, result clamped to minimum 1.
REQ-024 Divider latency 33 cycles from launch to result valid; a new tone change during a divide aborts and restarts it.
REQ-025 Until a new result is valid, the previous half_period keeps driving audio; on result valid, half-period counter clears to 0 and new half_period takes effect.
REQ-026 In PLAY with non-rest tone and a valid half_period: half-period counter counts 0..half_period-1, audio toggles at terminal count.
REQ-027 In IDLE, PAUSE, DONE: audio=0, half-period counter=0; on resume the wave restarts from audio=0.

Reset
REQ-028 rst forces IDLE, beat_num=0, audio=0, busy=0, done=0, prescaler=0, divider idle, half_period valid flag=0.
REQ-029 rst mid-divide or mid-beat discards all in-flight state; first post-reset start behaves as from power-up.

Structure
REQ-030 Shared package holds FSM state encoding, REST_HZ=20000 constant, and beat-index width (8).
REQ-031 One sub-module, half_period_div: 32-bit restoring serial divider with start/abort/valid handshake, computing dividend/divisor in 32 iterations plus one result cycle.

Verification (CLK_HZ=1000, BEAT_HZ=100 -> 10 cycles/beat unless stated)
REQ-032 Reset: assert rst 2 cycles -> beat_num=0, audio=0, busy=0, done=0.
REQ-033 start, tone=50 constant -> beat_num steps 0,1,2 every 10 cycles; within 34 cycles audio toggles every 10 cycles.
REQ-034 LOOP=0, LAST_BEAT=3, start -> done high exactly one cycle 40 cycles after start, beat_num=3, busy=0, audio=0 thereafter.
REQ-035 pause at 4 cycles into beat 2 held 50 cycles, then pause -> beat_num stays 2, audio=0 while paused; beat 3 begins 6 PLAY cycles after resume.
REQ-036 tone=20000 -> audio constant 0; tone 50->25 change 10 cycles into a divide -> only the 25 Hz result (half_period=20) applied.
REQ-037 start and stop same cycle in IDLE -> remains IDLE, busy=0; LOOP=1, LAST_BEAT=3 -> beat_num wraps 3->0 with no done pulse.

Source files
------------

// File: rtl/music_player_pkg.sv
// Shared definitions for the music player: FSM state encoding, the
// audible-range ceiling used to detect rests, and the beat index width.
package music_player_pkg;

  localparam int          BEAT_W  = 8;
  localparam logic [31:0] REST_HZ = 32'd20000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A tone of 0 Hz or anything at/above the audible ceiling is silence.
  function automatic logic is_rest(input logic [31:0] hz);
    return (hz == 32'd0) || (hz >= REST_HZ);
  endfunction

endpackage

// File: rtl/half_period_div.sv
// half_period_div: 32-bit restoring serial divider.
//   clk, rst           clock and synchronous active-high reset
//   start              load dividend/divisor and (re)start; restarts a
//                      divide already in flight
//   abort              drop any divide in flight without a result
//   dividend, divisor  operands, sampled when start is high
//   valid              one-cycle pulse when quotient is updated
//   quotient           floor(dividend/divisor), never less than 1
// One quotient bit per cycle for 32 cycles, then one result cycle, so
// valid rises 33 cycles after the start edge.
module half_period_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        valid,
  output logic [31:0] quotient
);

  logic        running;
  logic        finishing;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [32:0] shifted;
  logic        fits;

  // A zero result is clamped to 1 so the tone counter always has a period.
  function automatic logic [31:0] clamp_min1(input logic [31:0] q);
    return (q == 32'd0) ? 32'd1 : q;
  endfunction

  assign shifted = {rem, quo[31]};
  assign fits    = shifted >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      running   <= 1'b0;
      finishing <= 1'b0;
      valid     <= 1'b0;
      cnt       <= 5'd0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        running   <= 1'b1;
        finishing <= 1'b0;
        cnt       <= 5'd0;
      end else if (abort) begin
        running   <= 1'b0;
        finishing <= 1'b0;
      end else if (running) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          running   <= 1'b0;
          finishing <= 1'b1;
        end
      end else if (finishing) begin
        finishing <= 1'b0;
        valid     <= 1'b1;
      end
    end
  end

  // Datapath: quo shifts the dividend out and the quotient in. When the
  // trial subtraction fits, the difference is below dvs and fits 32 bits.
  always_ff @(posedge clk) begin
    if (start) begin
      rem <= 32'd0;
      quo <= dividend;
      dvs <= divisor;
    end else if (running) begin
      rem <= fits ? (shifted[31:0] - dvs) : shifted[31:0];
      quo <= {quo[30:0], fits};
    end
    if (finishing) quotient <= clamp_min1(quo);
  end

endmodule

// File: rtl/music_player.sv
// music_player: steps a song table one quarter-beat at a time and drives a
// square wave at the table's tone frequency.
//   clk, rst            clock, synchronous active-high reset
//   start, pause, stop  single-cycle command pulses (stop > start > pause)
//   tone                note in Hz from the song table for beat_num
//   beat_num            current quarter-beat index
//   audio               speaker drive
//   busy                high while playing or paused
//   done                one-cycle pulse when a non-looping song ends
module music_player
  import music_player_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BEAT_HZ   = 8,
  parameter int LAST_BEAT = 127,
  parameter int LOOP      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [31:0]       tone,
  output logic [BEAT_W-1:0] beat_num,
  output logic              audio,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0]       PRESC_MAX = 32'(CLK_HZ / BEAT_HZ - 1);
  localparam logic [BEAT_W-1:0] LAST_B    = BEAT_W'(LAST_BEAT);

  state_t      state;
  state_t      state_nx;
  logic [31:0] presc;
  logic        beat_tick;
  logic        last_tick;
  logic        restart;
  logic        playing;
  logic        run;

  logic [31:0] tone_p0;
  logic [31:0] last_tone;
  logic        launch;
  logic        div_valid;
  logic [31:0] div_q;
  logic [31:0] half_period;
  logic        hp_valid;
  logic [31:0] hp_cnt;

  assign beat_tick = (state == ST_PLAY) && (presc == PRESC_MAX);
  assign last_tick = beat_tick && (beat_num == LAST_B);
  assign restart   = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (stop)                             state_nx = ST_IDLE;
    else if (restart)                     state_nx = ST_PLAY;
    else if (last_tick && (LOOP == 0))    state_nx = ST_DONE;
    else if (pause && state == ST_PLAY)   state_nx = ST_PAUSE;
    else if (pause && state == ST_PAUSE)  state_nx = ST_PLAY;
  end

  always_comb begin
    busy    = (state == ST_PLAY) || (state == ST_PAUSE);
    playing = (state == ST_PLAY);
    // The wave only runs on cycles that stay in PLAY, so any command that
    // leaves PLAY silences the output on the same edge.
    run     = playing && (state_nx == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= playing && (state_nx == ST_DONE);
  end

  // Beat sequencing; the prescaler simply holds its value outside PLAY.
  always_ff @(posedge clk) begin
    if (rst || stop || restart) begin
      presc    <= 32'd0;
      beat_num <= '0;
    end else if (playing) begin
      if (beat_tick) begin
        presc <= 32'd0;
        if (beat_num != LAST_B)  beat_num <= beat_num + BEAT_W'(1);
        else if (LOOP != 0)      beat_num <= '0;
      end else begin
        presc <= presc + 32'd1;
      end
    end
  end

  // ---- stage p0: registered tone, divide launch on change ----
  always_ff @(posedge clk) tone_p0 <= tone;

  assign launch = !is_rest(tone_p0) && (tone_p0 != last_tone);

  always_ff @(posedge clk) begin
    if (rst)         last_tone <= 32'd0;
    else if (launch) last_tone <= tone_p0;
  end

  // A fresh launch restarts the divider, so abort is never needed here.
  half_period_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (launch),
    .abort    (1'b0),
    .dividend (32'(CLK_HZ)),
    .divisor  ({tone_p0[30:0], 1'b0}),
    .valid    (div_valid),
    .quotient (div_q)
  );

  // ---- stage p1: half-period update and square-wave generation ----
  always_ff @(posedge clk) begin
    if (rst)            hp_valid <= 1'b0;
    else if (div_valid) hp_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (div_valid) half_period <= div_q;
  end

  always_ff @(posedge clk) begin
    if (rst || stop || !run || is_rest(tone_p0) || !hp_valid) begin
      audio  <= 1'b0;
      hp_cnt <= 32'd0;
    end else if (div_valid) begin
      hp_cnt <= 32'd0;
    end else if (hp_cnt == half_period - 32'd1) begin
      hp_cnt <= 32'd0;
      audio  <= ~audio;
    end else begin
      hp_cnt <= hp_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_music_player.sv
module tb_music_player;

  localparam int CPB  = 10;   // 1000 Hz clock / 100 Hz beat
  localparam int LAST = 3;
  localparam int SONG = (LAST + 1) * CPB;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [31:0] tone = 32'd50;
  logic [7:0]  beat_a, beat_b;
  logic        audio_a, audio_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  music_player #(.CLK_HZ(1000), .BEAT_HZ(100), .LAST_BEAT(LAST), .LOOP(1)) u_loop (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .tone(tone),
    .beat_num(beat_a), .audio(audio_a), .busy(busy_a), .done(done_a));

  music_player #(.CLK_HZ(1000), .BEAT_HZ(100), .LAST_BEAT(LAST), .LOOP(0)) u_once (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .tone(tone),
    .beat_num(beat_b), .audio(audio_b), .busy(busy_b), .done(done_b));

  // Reference model: state plus elapsed PLAY cycles since the last start.
  typedef struct { int st; int e; bit dn; } mdl_t;
  mdl_t ma, mb;

  typedef struct { bit s; bit sp; bit pz; int beat; int busy; } vec_t;

  int n_chk = 0, n_pass = 0, cyc_n = 0;
  int tq[$];
  bit rec = 0;
  bit prev_a = 0;

  function automatic mdl_t mstep(mdl_t m, bit s, bit sp, bit pz, bit loop);
    mdl_t n = m;
    n.dn = 0;
    if (sp) begin
      n.st = M_IDLE; n.e = 0;
    end else if (s && (m.st == M_IDLE || m.st == M_DONE)) begin
      n.st = M_PLAY; n.e = 0;
    end else if (m.st == M_PLAY) begin
      n.e = m.e + 1;
      if (!loop && n.e == SONG) begin n.st = M_DONE; n.dn = 1; end
      else if (pz) n.st = M_PAUSE;
    end else if (m.st == M_PAUSE && pz) begin
      n.st = M_PLAY;
    end
    return n;
  endfunction

  function automatic int mbeat(mdl_t m, bit loop);
    if (m.st == M_IDLE) return 0;
    if (m.st == M_DONE) return LAST;
    return loop ? (m.e / CPB) % (LAST + 1) : m.e / CPB;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
  endtask

  task automatic mreset();
    ma = '{M_IDLE, 0, 0};
    mb = '{M_IDLE, 0, 0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mreset();
    prev_a = 0;
    chk("rst_beat_a", beat_a, 0);  chk("rst_beat_b", beat_b, 0);
    chk("rst_audio_a", audio_a, 0); chk("rst_audio_b", audio_b, 0);
    chk("rst_busy_a", busy_a, 0);  chk("rst_busy_b", busy_b, 0);
    chk("rst_done_a", done_a, 0);  chk("rst_done_b", done_b, 0);
  endtask

  // One clock with the given command pulses; both DUTs checked against the model.
  task automatic cyc(input bit s, input bit sp, input bit pz);
    start = s; stop = sp; pause = pz;
    ma = mstep(ma, s, sp, pz, 1'b1);
    mb = mstep(mb, s, sp, pz, 1'b0);
    @(posedge clk);
    #1;
    start = 0; stop = 0; pause = 0;
    cyc_n++;
    chk("beat_loop", beat_a, mbeat(ma, 1'b1));
    chk("beat_once", beat_b, mbeat(mb, 1'b0));
    chk("busy_loop", busy_a, (ma.st == M_PLAY || ma.st == M_PAUSE) ? 1 : 0);
    chk("busy_once", busy_b, (mb.st == M_PLAY || mb.st == M_PAUSE) ? 1 : 0);
    chk("done_loop", done_a, ma.dn);
    chk("done_once", done_b, mb.dn);
    if (ma.st != M_PLAY) chk("audio_quiet_loop", audio_a, 0);
    if (mb.st != M_PLAY) chk("audio_quiet_once", audio_b, 0);
    if (rec && audio_a != prev_a) tq.push_back(cyc_n);
    prev_a = audio_a;
  endtask

  initial begin
    vec_t vt[11];
    int t0, k, hits, n10;
    int tones[8];
    vt = '{
      '{0,0,0, 0,0}, '{1,1,0, 0,0}, '{0,0,1, 0,0}, '{1,0,0, 0,1},
      '{0,0,1, 0,1}, '{1,0,0, 0,1}, '{0,0,1, 0,1}, '{1,0,0, 0,1},
      '{0,1,1, 0,0}, '{1,0,1, 0,1}, '{0,1,0, 0,0}};
    tones = '{0, 25, 50, 40, 100, 20000, 20001, 19999};

    do_reset();

    // Command table: start/stop collisions, ignored commands, pause toggling.
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].s, vt[i].sp, vt[i].pz);
      chk($sformatf("tbl%0d_beat", i), beat_a, vt[i].beat);
      chk($sformatf("tbl%0d_busy", i), busy_a, vt[i].busy);
    end

    // 50 Hz tone: 10-cycle half period once the divide has settled.
    repeat (40) cyc(0, 0, 0);
    tq.delete(); rec = 1;
    cyc(1, 0, 0);
    t0 = cyc_n;
    repeat (60) cyc(0, 0, 0);
    rec = 0;
    chk("tone50_toggles_ge4", (tq.size() >= 4) ? 1 : 0, 1);
    if (tq.size() >= 1) chk("tone50_first_within34", (tq[0] - t0 <= 34) ? 1 : 0, 1);
    for (int i = 1; i < tq.size(); i++) chk("tone50_interval", tq[i] - tq[i-1], 10);
    cyc(0, 1, 0);

    // Non-looping song ends with a single done pulse 40 cycles after start;
    // the looping instance wraps 3 -> 0 with no done.
    cyc(1, 0, 0);
    hits = 0; t0 = -1; n10 = 0;
    for (int i = 1; i <= 50; i++) begin
      k = beat_a;
      cyc(0, 0, 0);
      if (done_b) begin hits++; t0 = i; end
      if (k == 3 && beat_a == 0) n10++;
      if (done_a) n10 = -100;
    end
    chk("once_done_count", hits, 1);
    chk("once_done_cycle", t0, 40);
    chk("once_final_beat", beat_b, 3);
    chk("once_final_busy", busy_b, 0);
    chk("loop_wrapped_no_done", (n10 >= 1) ? 1 : 0, 1);
    cyc(0, 1, 0);

    // Pause 4 cycles into beat 2, hold 50 cycles, resume.
    cyc(1, 0, 0);
    repeat (23) cyc(0, 0, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 50; i++) begin
      cyc(0, 0, 0);
      if (i % 10 == 0) begin
        chk("paused_beat", beat_a, 2);
        chk("paused_audio", audio_a, 0);
      end
    end
    cyc(0, 0, 1);
    k = 0;
    while (beat_a != 3 && k < 20) begin
      cyc(0, 0, 0);
      k++;
    end
    chk("resume_cycles_to_beat3", k, 6);
    cyc(0, 1, 0);

    // Rest tone keeps the speaker silent.
    tone = 32'd20000;
    cyc(1, 0, 0);
    for (int i = 0; i < 50; i++) begin
      cyc(0, 0, 0);
      if (i % 5 == 0) chk("rest_audio", audio_a, 0);
    end

    // 50 -> 25 change mid-divide: only the 25 Hz result may ever apply.
    tone = 32'd30;
    repeat (40) cyc(0, 0, 0);
    tq.delete(); rec = 1;
    tone = 32'd50;
    repeat (10) cyc(0, 0, 0);
    tone = 32'd25;
    repeat (150) cyc(0, 0, 0);
    rec = 0;
    n10 = 0;
    for (int i = 1; i < tq.size(); i++) if (tq[i] - tq[i-1] == 10) n10++;
    chk("abort_no_50hz_interval", n10, 0);
    chk("abort_toggles_ge5", (tq.size() >= 5) ? 1 : 0, 1);
    if (tq.size() >= 4)
      for (int i = tq.size() - 3; i < tq.size(); i++)
        chk("tone25_interval", tq[i] - tq[i-1], 20);
    cyc(0, 1, 0);

    // Randomized commands, tones and occasional resets against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 49) == 0) tone = tones[$urandom_range(0, 7)];
        r = $urandom_range(0, 99);
        cyc(r < 3, r == 99, r >= 3 && r < 6);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
